// File: rtl/wfg_memory_reader.sv
// Read initiator for the 1024x32 sample memory. It sweeps addresses from
// start to end inclusive, wrapping back to start, and streams the returned
// words out through a 2-entry FIFO.
//
// Stream handshake: valid_o stays high while the FIFO holds a word. data_o and
// wrap_o stay stable until a transfer. A transfer happens on any clock edge
// where valid_o && ready_i, and the FIFO head is popped on that edge.
//
// Read credit: a read is issued only when the words held, plus the word in
// flight, plus the new word, minus this cycle's pop fit in 2 slots. A returning
// word therefore always has a free slot.
module wfg_memory_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  output logic                  csb,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  wrap_o,
  output logic                  state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] start_q, end_q, ptr_q, addr_q;
  logic                  inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q;

  logic                  en_rise, pop, push, issue, credit_ok, flush;

  assign en_rise   = en_i && !en_q;
  assign valid_o   = (count_q != 2'd0);
  assign data_o    = fifo_data[rd_ptr_q];
  assign pop       = valid_o && ready_i;
  assign wrap_o    = pop && fifo_last[rd_ptr_q];
  assign push      = inflight_q;
  assign flush     = (state_q == RUN) && !en_i;
  assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q} + 3'd1 - {2'b00, pop}) <= 3'd2;
  assign state_dbg = state_q;

  // Next-state logic and read-port drive; addr holds its last value when idle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (en_rise) state_d = RUN;
      RUN: begin
        if (!en_i) state_d = IDLE;
        issue = en_i && !rst && credit_ok;
      end
      default: state_d = IDLE;
    endcase
    csb  = !issue;
    addr = issue ? ptr_q : addr_q;
  end

  // State, sweep pointer, in-flight tracking and return FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      // Treat the enable level present at reset as already seen, so a new sweep
      // needs a fresh rising edge.
      en_q            <= 1'b1;
      start_q         <= '0;
      end_q           <= '0;
      ptr_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      en_q    <= en_i;
      state_q <= state_d;
      if ((state_q == IDLE) && en_rise) begin
        start_q <= start_addr_i;
        end_q   <= end_addr_i;
        ptr_q   <= start_addr_i;
      end
      if (issue) begin
        addr_q <= ptr_q;
        ptr_q  <= (ptr_q == end_q) ? start_q : ptr_q + 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= (ptr_q == end_q);
      if (flush) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr_q] <= dout;
          fifo_last[wr_ptr_q] <= inflight_last_q;
          wr_ptr_q            <= !wr_ptr_q;
        end
        if (pop) rd_ptr_q <= !rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_wfg_memory_reader.sv
// Directed bench for wfg_memory_reader with a one-cycle-latency memory model
// holding word = address.
module tb_wfg_memory_reader;

  logic        clk = 1'b0;
  logic        rst, en_i, ready_i;
  logic [9:0]  start_addr_i, end_addr_i, addr;
  logic        csb, valid_o, wrap_o, state_dbg;
  logic [31:0] dout = '0;
  logic [31:0] data_o;

  wfg_memory_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .start_addr_i(start_addr_i),
    .end_addr_i(end_addr_i), .csb(csb), .addr(addr), .dout(dout),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .wrap_o(wrap_o),
    .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory model: data appears the cycle after csb=0 is registered.
  always @(posedge clk) if (!csb) dout <= {22'b0, addr};

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  sb_end;
  logic        s_v, s_csb, s_w, s_st;
  logic [31:0] s_d;
  logic [9:0]  s_a;
  bit          trk;
  int          m_cnt, m_infl;
  logic [9:0]  m_ptr, m_start, m_end;
  bit          p_v, p_r;
  logic [31:0] p_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive ready, sample mid-cycle, score transfers and credit.
  task automatic cyc(input logic rdy);
    logic [31:0] e;
    int          pop_i, exp_csb;
    ready_i = rdy;
    @(negedge clk);
    s_v = valid_o; s_d = data_o; s_csb = csb; s_a = addr; s_w = wrap_o; s_st = state_dbg;
    pop_i = (valid_o && ready_i) ? 1 : 0;
    if (pop_i == 1) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", data_o, e);
        chk("wrap", {31'b0, wrap_o}, {31'b0, (e[9:0] == sb_end)});
      end
    end else begin
      chk("wrap_idle", {31'b0, wrap_o}, 0);
    end
    if (trk) begin
      if (p_v && !p_r) begin
        chk("hold_valid", {31'b0, valid_o}, 1);
        chk("hold_data", data_o, p_d);
      end
      exp_csb = ((m_cnt + m_infl + 1 - pop_i) <= 2) ? 0 : 1;
      chk("csb_credit", {31'b0, csb}, exp_csb);
      if (exp_csb == 0) begin
        chk("addr", {22'b0, addr}, {22'b0, m_ptr});
        m_ptr = (m_ptr == m_end) ? m_start : m_ptr + 10'd1;
      end
      m_cnt  = m_cnt + m_infl - pop_i;
      m_infl = (exp_csb == 0) ? 1 : 0;
    end
    p_v = valid_o; p_r = ready_i; p_d = data_o;
    @(posedge clk); #1;
  endtask

  // Raise enable with a new window and check the start-up latency.
  task automatic start_run(input logic [9:0] s, input logic [9:0] e);
    logic [9:0] a;
    exp_q.delete();
    a = s;
    for (int i = 0; i < 80; i++) begin
      exp_q.push_back({22'b0, a});
      a = (a == e) ? s : a + 10'd1;
    end
    sb_end = e; m_start = s; m_end = e; m_ptr = s;
    start_addr_i = s; end_addr_i = e; en_i = 1'b1;
    cyc(1);
    chk("idle_valid", {31'b0, s_v}, 0);
    chk("idle_csb", {31'b0, s_csb}, 1);
    trk = 1'b1; m_cnt = 0; m_infl = 0; p_v = 1'b0;
    cyc(1);
    chk("entry_csb", {31'b0, s_csb}, 0);
    chk("entry_state", {31'b0, s_st}, 1);
    cyc(1);
    chk("lat_valid0", {31'b0, s_v}, 0);
    cyc(1);
    chk("first_valid", {31'b0, s_v}, 1);
    chk("first_data", s_d, {22'b0, s});
  endtask

  // Drop enable and confirm the stream goes quiet next cycle.
  task automatic stop_run();
    trk = 1'b0; en_i = 1'b0;
    cyc(1);
    exp_q.delete();
    cyc(1);
    chk("stop_valid", {31'b0, s_v}, 0);
    chk("stop_csb", {31'b0, s_csb}, 1);
  endtask

  logic [0:5] bp_pat = 6'b100101;

  initial begin
    rst = 1'b1; en_i = 1'b0; ready_i = 1'b0; trk = 1'b0;
    start_addr_i = '0; end_addr_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0);
    chk("rst_csb", {31'b0, s_csb}, 1);
    chk("rst_addr", {22'b0, s_a}, 0);
    chk("rst_valid", {31'b0, s_v}, 0);
    chk("rst_data", s_d, 0);
    chk("rst_state", {31'b0, s_st}, 0);

    // Continuous ready, window 5..8; a start change mid-run must be ignored.
    start_run(10'd5, 10'd8);
    start_addr_i = 10'd100;
    for (int i = 0; i < 14; i++) cyc(1);
    stop_run();

    // Sweep through the top of the address space.
    start_run(10'd1022, 10'd1);
    for (int i = 0; i < 10; i++) cyc(1);
    stop_run();

    // Backpressure, then abort while stalled.
    start_run(10'd0, 10'd15);
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 6; i++) cyc(bp_pat[i]);
    for (int i = 0; i < 4; i++) cyc(0);
    chk("stall_csb", {31'b0, s_csb}, 1);
    trk = 1'b0; en_i = 1'b0;
    cyc(0);
    exp_q.delete();
    start_run(10'd50, 10'd60);
    for (int i = 0; i < 8; i++) cyc(1);
    stop_run();

    // Single-word sweep, then reset mid-operation.
    start_run(10'd300, 10'd300);
    for (int i = 0; i < 8; i++) cyc(1);
    trk = 1'b0; rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    cyc(1);
    chk("mid_rst_csb", {31'b0, s_csb}, 1);
    chk("mid_rst_addr", {22'b0, s_a}, 0);
    chk("mid_rst_valid", {31'b0, s_v}, 0);
    chk("mid_rst_data", s_d, 0);
    chk("mid_rst_wrap", {31'b0, s_w}, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("post_rst_valid", {31'b0, s_v}, 0);
      chk("post_rst_csb", {31'b0, s_csb}, 1);
    end
    en_i = 1'b0;
    cyc(1);
    start_run(10'd5, 10'd8);
    for (int i = 0; i < 6; i++) cyc(1);
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
